// File: rtl/alu_div_iter.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with valid/ready on both sides.
// Optional macro DIV_EARLY_OUT_EN: skip the iterations when the divisor is zero or |dividend| < |divisor|.
module alu_div_iter #(
  parameter  int DATA_LEN = 32,
  localparam int CNT_W    = $clog2(DATA_LEN) + 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  signed_i,
  input  logic [DATA_LEN-1:0]   opdata1_i,
  input  logic [DATA_LEN-1:0]   opdata2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*DATA_LEN-1:0] result_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_LEN-1:0] rem, quo, mag2, op1_raw;
  logic                q_neg, r_neg;
  logic [DATA_LEN-1:0] mag1_in, mag2_in;
  logic [DATA_LEN:0]   shifted, diff;
  logic                accept, last, early;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);

  assign mag1_in = (signed_i && opdata1_i[DATA_LEN-1]) ? -opdata1_i : opdata1_i;
  assign mag2_in = (signed_i && opdata2_i[DATA_LEN-1]) ? -opdata2_i : opdata2_i;
  assign accept  = in_valid_i && in_ready_o && !flush_i;
  // One extra CALC cycle with cnt == DATA_LEN hands over to FIX.
  assign last    = (cnt == CNT_W'(DATA_LEN));

  // Shifted partial remainder is one bit wider; diff MSB is the borrow.
  assign shifted = {rem, quo[DATA_LEN-1]};
  assign diff    = shifted - {1'b0, mag2};

`ifdef DIV_EARLY_OUT_EN
  assign early = (mag2_in == '0) || (mag1_in < mag2_in);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept)      state_n = CALC;
      CALC: if (last)        state_n = FIX;
      FIX:                   state_n = DONE;
      DONE: if (out_ready_i) state_n = IDLE;
      default:               state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      mag2     <= '0;
      op1_raw  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
    end else if (!flush_i) begin
      case (state)
        IDLE: if (accept) begin
          op1_raw <= opdata1_i;
          mag2    <= mag2_in;
          q_neg   <= signed_i & (opdata1_i[DATA_LEN-1] ^ opdata2_i[DATA_LEN-1]);
          r_neg   <= signed_i & opdata1_i[DATA_LEN-1];
          if (early) begin
            // Preloading the finished state leaves only the hand-over cycle.
            cnt <= CNT_W'(DATA_LEN);
            rem <= mag1_in;
            quo <= '0;
          end else begin
            cnt <= '0;
            rem <= '0;
            quo <= mag1_in;
          end
        end
        CALC: if (!last) begin
          rem <= diff[DATA_LEN] ? shifted[DATA_LEN-1:0] : diff[DATA_LEN-1:0];
          quo <= {quo[DATA_LEN-2:0], ~diff[DATA_LEN]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (mag2 == '0) result_o <= {op1_raw, {DATA_LEN{1'b1}}};
          else            result_o <= {(r_neg ? -rem : rem), (q_neg ? -quo : quo)};
        end
        default: ;
      endcase
    end
  end

endmodule
